// File: rtl/bp_nonsynth_io_responder.sv
// bp_nonsynth_io_responder: behavioural IO endpoint answering uc_rd/uc_wr BedRock mem commands
//   against a local array of io_data_width_p-bit words. Latency: rd response one cycle after
//   header accept, wr response one cycle after last beat. Backpressure: one command in flight;
//   command readies drop until both response handshakes (header, and data for reads) complete.
// Ports: clk_i/reset_n_i; io_cmd_* header+data stream in; io_resp_* header+data stream out;
//   wr_count_o/rd_count_o saturating completion counters; error_o sticky protocol/address error.
// Header layout (MSB..LSB): payload[payload_width_p] | size[3] | addr[paddr_width_p] | subop[4] | msg_type[4]
module bp_nonsynth_io_responder #(
    parameter int                       paddr_width_p   = 40,
    parameter int                       payload_width_p = 16,
    parameter int                       io_data_width_p = 64,
    parameter int                       els_p           = 1024,
    parameter logic [paddr_width_p-1:0] base_addr_p     = '0,
    localparam int mem_header_width_lp = payload_width_p + 3 + paddr_width_p + 8
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,

    input  logic [mem_header_width_lp-1:0] io_cmd_header_i,
    input  logic                           io_cmd_header_v_i,
    output logic                           io_cmd_header_ready_and_o,
    input  logic                           io_cmd_has_data_i,
    input  logic [io_data_width_p-1:0]     io_cmd_data_i,
    input  logic                           io_cmd_data_v_i,
    output logic                           io_cmd_data_ready_and_o,
    input  logic                           io_cmd_last_i,

    output logic [mem_header_width_lp-1:0] io_resp_header_o,
    output logic                           io_resp_header_v_o,
    input  logic                           io_resp_header_ready_and_i,
    output logic                           io_resp_has_data_o,
    output logic [io_data_width_p-1:0]     io_resp_data_o,
    output logic                           io_resp_data_v_o,
    input  logic                           io_resp_data_ready_and_i,
    output logic                           io_resp_last_o,

    output logic [31:0]                    wr_count_o,
    output logic [31:0]                    rd_count_o,
    output logic                           error_o
);

    localparam int bytes_lp = io_data_width_p / 8;
    localparam int idx_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam logic [paddr_width_p-1:0] win_bytes_lp = paddr_width_p'(els_p * 8);
    localparam logic [3:0] uc_rd_lp = 4'd2;
    localparam logic [3:0] uc_wr_lp = 4'd3;

    typedef struct packed {
        logic [payload_width_p-1:0] payload;
        logic [2:0]                 size;
        logic [paddr_width_p-1:0]   addr;
        logic [3:0]                 subop;
        logic [3:0]                 msg_type;
    } hdr_t;

    typedef enum logic [1:0] {e_ready, e_data, e_resp} state_e;

    // Selected field, shifted down from its byte offset and replicated over the beat.
    function automatic logic [io_data_width_p-1:0] fmt_rd(input logic [io_data_width_p-1:0] word,
                                                          input logic [2:0] off,
                                                          input logic [1:0] sz);
        logic [io_data_width_p-1:0] sh;
        logic [io_data_width_p-1:0] r;
        int sb;
        sh = word >> {off, 3'b000};
        sb = 1 << sz;
        r  = '0;
        for (int i = 0; i < bytes_lp; i++) begin
            r[i*8 +: 8] = sh[(i & (sb - 1))*8 +: 8];
        end
        return r;
    endfunction

    // Bytes [off, off+size) replaced by the low bytes of the beat.
    function automatic logic [io_data_width_p-1:0] merge_wr(input logic [io_data_width_p-1:0] word,
                                                            input logic [io_data_width_p-1:0] data,
                                                            input logic [2:0] off,
                                                            input logic [1:0] sz);
        logic [io_data_width_p-1:0] r;
        int lo;
        int sb;
        r  = word;
        lo = int'(off);
        sb = 1 << sz;
        for (int i = 0; i < bytes_lp; i++) begin
            if (i >= lo && i < lo + sb) begin
                r[i*8 +: 8] = data[(i - lo)*8 +: 8];
            end
        end
        return r;
    endfunction

    logic [io_data_width_p-1:0] mem_r [els_p];

    state_e                     state_q, state_d;
    hdr_t                       hdr_q, hdr_d;
    logic [2:0]                 off_q, off_d;
    logic [1:0]                 sz_q, sz_d;
    logic [idx_w_lp-1:0]        idx_q, idx_d;
    logic                       ok_q, ok_d;
    logic                       is_rd_q, is_rd_d;
    logic                       is_wr_q, is_wr_d;
    logic                       beat0_q, beat0_d;
    logic                       hdr_done_q, hdr_done_d;
    logic                       data_done_q, data_done_d;
    logic [io_data_width_p-1:0] rd_data_q, rd_data_d;
    logic [31:0]                wr_cnt_q, wr_cnt_d;
    logic [31:0]                rd_cnt_q, rd_cnt_d;
    logic                       err_q, err_d;

    // Incoming header decode
    hdr_t                       cmd_hdr;
    logic [paddr_width_p:0]     cmd_diff;
    logic [paddr_width_p-1:0]   cmd_off_addr;
    logic                       cmd_in_win;
    logic [1:0]                 cmd_sz;
    logic [2:0]                 cmd_align_mask;
    logic                       cmd_misaligned;
    logic                       cmd_is_rd;
    logic                       cmd_is_wr;
    logic                       cmd_access_ok;
    logic                       cmd_bad;
    logic [idx_w_lp-1:0]        cmd_idx;

    logic                       cmd_hdr_hs;
    logic                       cmd_data_hs;
    logic                       resp_hdr_hs;
    logic                       resp_data_hs;
    logic                       mem_we;
    logic [io_data_width_p-1:0] mem_wdata;

    assign cmd_hdr      = hdr_t'(io_cmd_header_i);
    // Extra MSB of the difference is the borrow: set when addr is below the window base.
    assign cmd_diff     = {1'b0, cmd_hdr.addr} - {1'b0, base_addr_p};
    assign cmd_off_addr = cmd_diff[paddr_width_p-1:0];
    assign cmd_in_win   = !cmd_diff[paddr_width_p] && (cmd_off_addr < win_bytes_lp);
    // Oversized requests are serviced as a full word from beat 0.
    assign cmd_sz       = (cmd_hdr.size > 3'd3) ? 2'd3 : cmd_hdr.size[1:0];

    always_comb begin
        cmd_align_mask = 3'b000;
        unique case (cmd_sz)
            2'd0: cmd_align_mask = 3'b000;
            2'd1: cmd_align_mask = 3'b001;
            2'd2: cmd_align_mask = 3'b011;
            2'd3: cmd_align_mask = 3'b111;
            default: cmd_align_mask = 3'b111;
        endcase
    end

    assign cmd_misaligned = |(cmd_hdr.addr[2:0] & cmd_align_mask);
    assign cmd_is_rd      = (cmd_hdr.msg_type == uc_rd_lp);
    assign cmd_is_wr      = (cmd_hdr.msg_type == uc_wr_lp);
    assign cmd_access_ok  = (cmd_is_rd || cmd_is_wr) && cmd_in_win && !cmd_misaligned;
    assign cmd_bad        = !(cmd_is_rd || cmd_is_wr) || (cmd_hdr.size > 3'd3) || !cmd_in_win || cmd_misaligned;
    assign cmd_idx        = cmd_off_addr[idx_w_lp+2:3];

    // Header ready is masked by reset so nothing is offered while the block is held in reset.
    assign io_cmd_header_ready_and_o = reset_n_i && (state_q == e_ready);
    assign io_cmd_data_ready_and_o   = (state_q == e_data);
    assign io_resp_header_v_o        = (state_q == e_resp) && !hdr_done_q;
    assign io_resp_data_v_o          = (state_q == e_resp) && is_rd_q && !data_done_q;
    assign io_resp_has_data_o        = (state_q == e_resp) && is_rd_q;
    assign io_resp_last_o            = io_resp_data_v_o;
    assign io_resp_header_o          = hdr_q;
    assign io_resp_data_o            = rd_data_q;
    assign wr_count_o                = wr_cnt_q;
    assign rd_count_o                = rd_cnt_q;
    assign error_o                   = err_q;

    assign cmd_hdr_hs   = io_cmd_header_v_i && io_cmd_header_ready_and_o;
    assign cmd_data_hs  = io_cmd_data_v_i && io_cmd_data_ready_and_o;
    assign resp_hdr_hs  = io_resp_header_v_o && io_resp_header_ready_and_i;
    assign resp_data_hs = io_resp_data_v_o && io_resp_data_ready_and_i;

    assign mem_we    = cmd_data_hs && beat0_q && is_wr_q && ok_q;
    assign mem_wdata = merge_wr(mem_r[idx_q], io_cmd_data_i, off_q, sz_q);

    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        off_d       = off_q;
        sz_d        = sz_q;
        idx_d       = idx_q;
        ok_d        = ok_q;
        is_rd_d     = is_rd_q;
        is_wr_d     = is_wr_q;
        beat0_d     = beat0_q;
        hdr_done_d  = hdr_done_q;
        data_done_d = data_done_q;
        rd_data_d   = rd_data_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        err_d       = err_q || (cmd_hdr_hs && cmd_bad);

        unique case (state_q)
            e_ready: begin
                if (cmd_hdr_hs) begin
                    hdr_d       = cmd_hdr;
                    off_d       = cmd_hdr.addr[2:0];
                    sz_d        = cmd_sz;
                    idx_d       = cmd_idx;
                    ok_d        = cmd_access_ok;
                    is_rd_d     = cmd_is_rd;
                    is_wr_d     = cmd_is_wr;
                    rd_data_d   = (cmd_is_rd && cmd_access_ok)
                                  ? fmt_rd(mem_r[cmd_idx], cmd_hdr.addr[2:0], cmd_sz) : '0;
                    beat0_d     = 1'b1;
                    hdr_done_d  = 1'b0;
                    // Only reads owe a data beat on the response side.
                    data_done_d = !cmd_is_rd;
                    state_d     = io_cmd_has_data_i ? e_data : e_resp;
                end
            end
            e_data: begin
                if (cmd_data_hs) begin
                    beat0_d = 1'b0;
                    if (io_cmd_last_i) begin
                        state_d = e_resp;
                    end
                end
            end
            e_resp: begin
                hdr_done_d  = hdr_done_q || resp_hdr_hs;
                data_done_d = data_done_q || resp_data_hs;
                if (hdr_done_d && data_done_d) begin
                    state_d = e_ready;
                end
            end
            default: state_d = e_ready;
        endcase

        if (resp_hdr_hs && is_wr_q && (wr_cnt_q != '1)) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
        end
        if (resp_hdr_hs && is_rd_q && (rd_cnt_q != '1)) begin
            rd_cnt_d = rd_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= e_ready;
            hdr_q       <= '0;
            off_q       <= '0;
            sz_q        <= '0;
            idx_q       <= '0;
            ok_q        <= 1'b0;
            is_rd_q     <= 1'b0;
            is_wr_q     <= 1'b0;
            beat0_q     <= 1'b0;
            hdr_done_q  <= 1'b0;
            data_done_q <= 1'b0;
            rd_data_q   <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            off_q       <= off_d;
            sz_q        <= sz_d;
            idx_q       <= idx_d;
            ok_q        <= ok_d;
            is_rd_q     <= is_rd_d;
            is_wr_q     <= is_wr_d;
            beat0_q     <= beat0_d;
            hdr_done_q  <= hdr_done_d;
            data_done_q <= data_done_d;
            rd_data_q   <= rd_data_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            err_q       <= err_d;
        end
    end

    // Array contents survive reset; writes are impossible while reset holds state in e_ready.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_r[idx_q] <= mem_wdata;
        end
    end

endmodule
